rx_packet_ddr_writer: RTL and testbench



---
 rtl/rx_packet_ddr_writer_if.sv | 48 ++++
 rtl/rx_packet_ddr_writer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rx_packet_ddr_writer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_packet_ddr_writer_if.sv
`default_nettype none
// ==== rx_packet_ddr_writer_if : TSE RX byte stream + DDR RAM write port bundle ====
// ==== Rev 1.0                                                                  ====
interface rx_packet_ddr_writer_if #(
  parameter int ADDR_W = 25
) ();

  logic [7:0]        ff_rx_data;
  logic              ff_rx_sop;
  logic              ff_rx_eop;
  logic              ff_rx_dval;
  logic              ff_rx_err;
  logic              ff_rx_rdy;

  logic [ADDR_W-1:0] ram_address;
  logic [255:0]      ram_data_write;
  logic              ram_wren;
  logic              ram_ready;

  // master: the packet writer (sinks the RX stream, drives the RAM write port)
  modport master (
    input  ff_rx_data,
    input  ff_rx_sop,
    input  ff_rx_eop,
    input  ff_rx_dval,
    input  ff_rx_err,
    output ff_rx_rdy,
    output ram_address,
    output ram_data_write,
    output ram_wren,
    input  ram_ready
  );

  modport slave (
    output ff_rx_data,
    output ff_rx_sop,
    output ff_rx_eop,
    output ff_rx_dval,
    output ff_rx_err,
    input  ff_rx_rdy,
    input  ram_address,
    input  ram_data_write,
    input  ram_wren,
    output ram_ready
  );

endinterface
`default_nettype wire

// File: rtl/rx_packet_ddr_writer.sv
`default_nettype none
// ==== rx_packet_ddr_writer : packs RX bytes into 256-bit DDR words, then writes a length header ====
// ==== Rev 1.0 ; optional macro RX_CRC_STRIP_EN (length excludes the 4 FCS bytes)                 ====
module rx_packet_ddr_writer #(
  parameter int MAX_PKT_BYTES = 1536,
  parameter int ADDR_W        = 25
) (
  input  wire logic              clk_original,
  input  wire logic              rst_n,
  input  wire logic [ADDR_W-1:0] start_ram_addr,
  rx_packet_ddr_writer_if.master bus,
  output logic                   pkt_done,
  output logic [10:0]            pkt_len,
  output logic                   pkt_dropped,
  output logic                   busy
);

  localparam int c_CNT_W = 11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_FLUSH   = 3'd2,
    S_HEADER  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_up;
  logic [ADDR_W-1:0]   r_base, w_base_n;
  logic [c_CNT_W-1:0]  r_count, w_count_n;
  logic [255:0]        r_stage, w_stage_n;
  logic                r_ovf, w_ovf_n;
  logic                r_after_hdr, w_after_hdr_n;
  logic                r_after_drop, w_after_drop_n;
  logic [10:0]         r_len, w_len_n;
  logic [10:0]         r_pkt_len, w_pkt_len_n;
  logic                r_wren, w_wren_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [255:0]        r_wdata, w_wdata_n;
  logic                r_done, w_done_n;
  logic                r_drop, w_drop_n;

  logic                w_rdy;
  logic                w_accept;
  logic                w_restart;
  logic [c_CNT_W-1:0]  w_idx;
  logic [c_CNT_W-1:0]  w_cnt;
  logic [ADDR_W-1:0]   w_wbase;
  logic [7:0]          w_lane;
  logic [255:0]        w_packed;
  logic                w_full;
  logic [ADDR_W-1:0]   w_data_addr;
  logic [10:0]         w_final_len;
  logic                w_len_ok;
  logic                w_bad_end;
  logic [255:0]        w_hdr_word;
  logic                w_take;

  assign w_rdy     = r_up & ((r_state == S_IDLE) | (r_state == S_CAPTURE)) & ~r_wren;
  assign w_accept  = bus.ff_rx_dval & w_rdy;
  assign w_restart = w_accept & bus.ff_rx_sop;

  // A sop byte always restarts at byte 0 with a freshly sampled base
  assign w_idx   = w_restart ? '0 : r_count;
  assign w_cnt   = w_idx + c_CNT_W'(1);
  assign w_wbase = w_restart ? start_ram_addr : r_base;

  // Big-endian bytes within each 32-bit lane: byte b at lane b/4, bit offset (3-b%4)*8
  assign w_lane = {w_idx[4:2], ~w_idx[1:0], 3'b000};
  assign w_full = &w_idx[4:0];

  always_comb begin
    w_packed = w_restart ? '0 : r_stage;
    w_packed[w_lane +: 8] = bus.ff_rx_data;
  end

  assign w_data_addr = w_wbase + ADDR_W'(w_idx[c_CNT_W-1:5]) + ADDR_W'(1);
  assign w_hdr_word  = {245'b0, r_len};

`ifdef RX_CRC_STRIP_EN
  assign w_final_len = w_cnt - 11'd4;
  assign w_len_ok    = (w_cnt > c_CNT_W'(4));
`else
  assign w_final_len = w_cnt;
  assign w_len_ok    = 1'b1;
`endif

  assign w_bad_end = bus.ff_rx_err | ~w_len_ok;

  always_comb begin
    w_state_n      = r_state;
    w_base_n       = r_base;
    w_count_n      = r_count;
    w_stage_n      = r_stage;
    w_ovf_n        = r_ovf;
    w_after_hdr_n  = r_after_hdr;
    w_after_drop_n = r_after_drop;
    w_len_n        = r_len;
    w_pkt_len_n    = r_pkt_len;
    w_wren_n       = r_wren;
    w_addr_n       = r_addr;
    w_wdata_n      = r_wdata;
    w_done_n       = 1'b0;
    w_drop_n       = 1'b0;
    w_take         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_restart) w_take = 1'b1;
      end

      S_CAPTURE: begin
        if (r_wren) begin
          if (bus.ram_ready) begin
            w_wren_n = 1'b0;
            if (r_after_hdr) begin
              w_state_n = S_HEADER;
              w_wren_n  = 1'b1;
              w_addr_n  = r_base;
              w_wdata_n = w_hdr_word;
            end else if (r_after_drop) begin
              w_state_n = S_IDLE;
              w_drop_n  = 1'b1;
            end
          end
        end else if (w_accept) begin
          if (bus.ff_rx_sop) begin
            w_drop_n = 1'b1;
            w_take   = 1'b1;
          end else if (r_ovf || (r_count == c_CNT_W'(MAX_PKT_BYTES))) begin
            // Oversized: swallow the rest of the packet without storing it
            w_ovf_n = 1'b1;
            if (bus.ff_rx_eop) begin
              w_drop_n  = 1'b1;
              w_state_n = S_IDLE;
            end
          end else begin
            w_take = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (r_wren && bus.ram_ready) begin
          w_state_n = S_HEADER;
          w_addr_n  = r_base;
          w_wdata_n = w_hdr_word;
        end
      end

      S_HEADER: begin
        if (r_wren && bus.ram_ready) begin
          w_wren_n    = 1'b0;
          w_state_n   = S_DONE;
          w_done_n    = 1'b1;
          w_pkt_len_n = r_len;
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_take) begin
      w_base_n       = w_wbase;
      w_count_n      = w_cnt;
      w_ovf_n        = 1'b0;
      w_after_hdr_n  = 1'b0;
      w_after_drop_n = 1'b0;
      w_state_n      = S_CAPTURE;
      if (bus.ff_rx_eop) w_len_n = w_final_len;
      if (w_full) begin
        // A completed word is always written, even when the packet ends badly
        w_wren_n  = 1'b1;
        w_addr_n  = w_data_addr;
        w_wdata_n = w_packed;
        w_stage_n = '0;
        if (bus.ff_rx_eop) begin
          w_after_drop_n = w_bad_end;
          w_after_hdr_n  = ~w_bad_end;
        end
      end else begin
        w_stage_n = w_packed;
        if (bus.ff_rx_eop) begin
          if (w_bad_end) begin
            w_drop_n  = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_FLUSH;
            w_wren_n  = 1'b1;
            w_addr_n  = w_data_addr;
            w_wdata_n = w_packed;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_original) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_up         <= 1'b0;
      r_base       <= '0;
      r_count      <= '0;
      r_stage      <= '0;
      r_ovf        <= 1'b0;
      r_after_hdr  <= 1'b0;
      r_after_drop <= 1'b0;
      r_len        <= '0;
      r_pkt_len    <= '0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_up         <= 1'b1;
      r_base       <= w_base_n;
      r_count      <= w_count_n;
      r_stage      <= w_stage_n;
      r_ovf        <= w_ovf_n;
      r_after_hdr  <= w_after_hdr_n;
      r_after_drop <= w_after_drop_n;
      r_len        <= w_len_n;
      r_pkt_len    <= w_pkt_len_n;
      r_wren       <= w_wren_n;
      r_addr       <= w_addr_n;
      r_wdata      <= w_wdata_n;
      r_done       <= w_done_n;
      r_drop       <= w_drop_n;
    end
  end

  assign bus.ff_rx_rdy      = w_rdy;
  assign bus.ram_wren       = r_wren;
  assign bus.ram_address    = r_addr;
  assign bus.ram_data_write = r_wdata;
  assign pkt_done           = r_done;
  assign pkt_len            = r_pkt_len;
  assign pkt_dropped        = r_drop;
  assign busy               = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_packet_ddr_writer.sv
`default_nettype none
// ==== tb_rx_packet_ddr_writer : directed bench for rx_packet_ddr_writer with a DDR write-port model ====
module tb_rx_packet_ddr_writer;

  localparam int ADDR_W = 25;
  localparam int MAX    = 1536;
`ifdef RX_CRC_STRIP_EN
  localparam int CRC = 4;
`else
  localparam int CRC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              pkt_done, pkt_dropped, busy;
  logic [10:0]       pkt_len;

  rx_packet_ddr_writer_if #(.ADDR_W(ADDR_W)) bus ();

  rx_packet_ddr_writer #(.MAX_PKT_BYTES(MAX), .ADDR_W(ADDR_W)) dut (
    .clk_original   (clk),
    .rst_n          (rst_n),
    .start_ram_addr (start_addr),
    .bus            (bus),
    .pkt_done       (pkt_done),
    .pkt_len        (pkt_len),
    .pkt_dropped    (pkt_dropped),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // DDR model and event counters
  logic [255:0]      mem [logic [ADDR_W-1:0]];
  int                wr_count = 0, done_cnt = 0, drop_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [10:0]       last_len = '0;

  always @(posedge clk) begin
    if (bus.ram_wren && bus.ram_ready) begin
      mem[bus.ram_address] = bus.ram_data_write;
      wr_count++;
      last_addr = bus.ram_address;
    end
    if (pkt_done) begin
      done_cnt++;
      last_len = pkt_len;
    end
    if (pkt_dropped) drop_cnt++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {256{1'bx}};
  endfunction

  function automatic logic [255:0] pack(input int first, input int nb, input int seed);
    logic [255:0] w = '0;
    for (int b = 0; b < 32; b++)
      if (b < nb) w[(b/4)*32 + 31 - (b%4)*8 -: 8] = 8'(first + b + seed);
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop, input bit err,
                           input logic [ADDR_W-1:0] a);
    int guard = 0;
    @(negedge clk);
    start_addr     = a;
    bus.ff_rx_dval = 1'b1;
    bus.ff_rx_data = d;
    bus.ff_rx_sop  = sop;
    bus.ff_rx_eop  = eop;
    bus.ff_rx_err  = err;
    while (!bus.ff_rx_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("rdy_timeout", 256'(guard), 256'(0));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ff_rx_dval = 1'b0;
      bus.ff_rx_sop  = 1'b0;
      bus.ff_rx_eop  = 1'b0;
      bus.ff_rx_err  = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [ADDR_W-1:0] base, input int n, input int seed,
                          input bit err, input bit with_eop);
    for (int i = 0; i < n; i++)
      send_byte(8'(i + seed), i == 0, with_eop && (i == n-1), err && (i == n-1), base);
    idle(1);
  endtask

  task automatic check_pkt(input string t, input logic [ADDR_W-1:0] base, input int n, input int seed);
    int nw = (n + 31) / 32;
    for (int w = 0; w < nw; w++)
      chk($sformatf("%s_word%0d", t, w), rd(base + ADDR_W'(w + 1)),
          pack(w*32, (n - w*32 > 32) ? 32 : n - w*32, seed));
    chk({t, "_header"}, rd(base), 256'(n - CRC));
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_rdy"},     bus.ff_rx_rdy, 1'b0);
    chk({t, "_wren"},    bus.ram_wren, 1'b0);
    chk({t, "_addr"},    bus.ram_address, '0);
    chk({t, "_data"},    bus.ram_data_write, '0);
    chk({t, "_done"},    pkt_done, 1'b0);
    chk({t, "_len"},     pkt_len, '0);
    chk({t, "_dropped"}, pkt_dropped, 1'b0);
    chk({t, "_busy"},    busy, 1'b0);
  endtask

  initial begin
    int wr0, dn0, dp0;
    logic [255:0] w;

    bus.ff_rx_dval = 1'b0;
    bus.ff_rx_data = '0;
    bus.ff_rx_sop  = 1'b0;
    bus.ff_rx_eop  = 1'b0;
    bus.ff_rx_err  = 1'b0;
    bus.ram_ready  = 1'b1;

    // Reset state, then ready one cycle after release
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", bus.ff_rx_rdy, 1'b1);

    // 64-byte packet at 0x100
    wr0 = wr_count; dn0 = done_cnt;
    send_pkt(25'h100, 64, 0, 0, 1);
    idle(20);
    check_pkt("t1", 25'h100, 64, 0);
    w = rd(25'h101);
    chk("t1_byte0", w[31:24], 8'h00);
    chk("t1_byte3", w[7:0], 8'h03);
    chk("t1_writes", wr_count - wr0, 3);
    chk("t1_hdr_last", last_addr, 25'h100);
    chk("t1_done", done_cnt - dn0, 1);
    chk("t1_len", last_len, 11'(64 - CRC));
    chk("t1_busy_idle", busy, 1'b0);

    // 33-byte packet: the second word holds one byte
    send_pkt(25'h200, 33, 8'h80, 0, 1);
    idle(20);
    check_pkt("t2", 25'h200, 33, 8'h80);
    chk("t2_w1_hand", rd(25'h202), 256'hA000_0000);

    // 64-byte packet with the first write stalled 5 cycles
    dn0 = done_cnt;
    bus.ram_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'(i + 8'h40), i == 0, 1'b0, 1'b0, 25'h300);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.ff_rx_dval = 1'b0;
      bus.ff_rx_sop  = 1'b0;
      chk($sformatf("t3_stall%0d_wren", k), bus.ram_wren, 1'b1);
      chk($sformatf("t3_stall%0d_rdy", k), bus.ff_rx_rdy, 1'b0);
      chk($sformatf("t3_stall%0d_addr", k), bus.ram_address, 25'h301);
      chk($sformatf("t3_stall%0d_data", k), bus.ram_data_write, pack(0, 32, 8'h40));
    end
    bus.ram_ready = 1'b1;
    for (int i = 32; i < 64; i++) send_byte(8'(i + 8'h40), 1'b0, i == 63, 1'b0, 25'h300);
    idle(20);
    check_pkt("t3", 25'h300, 64, 8'h40);
    chk("t3_done", done_cnt - dn0, 1);

    // Errored packet, then a short good one
    dn0 = done_cnt; dp0 = drop_cnt;
    send_pkt(25'h400, 40, 8'h10, 1, 1);
    idle(10);
    chk("t4_dropped", drop_cnt - dp0, 1);
    chk("t4_no_done", done_cnt - dn0, 0);
    chk("t4_no_header", mem.exists(25'h400), 0);
    chk("t4_word0", rd(25'h401), pack(0, 32, 8'h10));
    chk("t4_no_flush", mem.exists(25'h402), 0);
    send_pkt(25'h500, 10, 8'h20, 0, 1);
    idle(20);
    check_pkt("t4b", 25'h500, 10, 8'h20);
    chk("t4b_done", done_cnt - dn0, 1);
    chk("t4b_len", last_len, 11'(10 - CRC));

    // Oversized packet
    wr0 = wr_count; dn0 = done_cnt; dp0 = drop_cnt;
    send_pkt(25'h1000, MAX + 10, 8'h33, 0, 1);
    idle(10);
    chk("t5_dropped", drop_cnt - dp0, 1);
    chk("t5_no_done", done_cnt - dn0, 0);
    chk("t5_no_header", mem.exists(25'h1000), 0);
    chk("t5_last_word", rd(25'h1030), pack(1504, 32, 8'h33));
    chk("t5_beyond", mem.exists(25'h1031), 0);
    chk("t5_writes", wr_count - wr0, 48);

    // sop while capturing: old packet dropped, new one stored at the new base
    dn0 = done_cnt; dp0 = drop_cnt;
    send_pkt(25'h2000, 20, 8'h05, 0, 0);
    send_pkt(25'h3000, 8, 8'h60, 0, 1);
    idle(20);
    chk("t5b_dropped", drop_cnt - dp0, 1);
    chk("t5b_done", done_cnt - dn0, 1);
    check_pkt("t5b", 25'h3000, 8, 8'h60);
    chk("t5b_old_hdr", mem.exists(25'h2000), 0);
    chk("t5b_old_word", mem.exists(25'h2001), 0);

    // Reset mid-packet
    dn0 = done_cnt; dp0 = drop_cnt;
    send_pkt(25'h4000, 20, 8'h70, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t6_rst");
    rst_n = 1'b1;
    idle(3);
    chk("t6_no_pulses", (done_cnt - dn0) + (drop_cnt - dp0), 0);
    send_pkt(25'h5000, 32, 8'h90, 0, 1);
    idle(20);
    check_pkt("t6", 25'h5000, 32, 8'h90);
    chk("t6_old_hdr", mem.exists(25'h4000), 0);
    chk("t6_len", last_len, 11'(32 - CRC));

    // 68-byte packet: header reflects FCS stripping when enabled
    send_pkt(25'h6000, 68, 8'hC0, 0, 1);
    idle(20);
    check_pkt("t7", 25'h6000, 68, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
